// File: rtl/mgmt_smbus_chan_arb_if.sv
// Request/grant bundle between the SMBus relay channels, the arbiter and the frame TX.
interface mgmt_smbus_chan_arb_if #(
   parameter int NUM_CH = 4,
   parameter int EVT_W  = 4
);
   localparam int CH_W = $clog2(NUM_CH);

   logic                      frm_slot;
   logic [NUM_CH-1:0]         req_valid;
   logic [NUM_CH*EVT_W-1:0]   req_evt;
   logic [NUM_CH-1:0]         req_ready;
   logic                      frm_valid;
   logic [CH_W-1:0]           frm_ch;
   logic [EVT_W-1:0]          frm_evt;
   logic                      frm_ack;

   modport master (
      output frm_slot, req_valid, req_evt, frm_ack,
      input  req_ready, frm_valid, frm_ch, frm_evt
   );

   modport slave (
      input  frm_slot, req_valid, req_evt, frm_ack,
      output req_ready, frm_valid, frm_ch, frm_evt
   );
endinterface

// File: rtl/mgmt_smbus_chan_arb.sv
// Round-robin arbiter feeding one SMBus relay event per management frame slot,
// holding it until the frame TX acks or dropping it after TIMEOUT SEND cycles.
module mgmt_smbus_chan_arb #(
   parameter int  NUM_CH  = 4,
   parameter int  EVT_W   = 4,
   parameter int  TIMEOUT = 256,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  err_clr,
   mgmt_smbus_chan_arb_if.slave  bus,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [7:0]            drop_cnt
);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state_q, state_d;
   logic              frm_valid_q, frm_valid_d;
   logic [CH_W-1:0]   frm_ch_q, frm_ch_d;
   logic [EVT_W-1:0]  frm_evt_q, frm_evt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              timeout_err_q, timeout_err_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

   logic              grant_found;
   logic [CH_W-1:0]   grant_idx;
   logic [CH_W-1:0]   cand;
   logic              accept;
   logic              drop;

   // Search starts just after the last winner so every channel gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign accept = reset_n && (state_q == IDLE) && enable && bus.frm_slot && grant_found;

   always_comb begin
      state_d       = state_q;
      frm_valid_d   = frm_valid_q;
      frm_ch_d      = frm_ch_q;
      frm_evt_d     = frm_evt_q;
      cnt_d         = cnt_q;
      rr_ptr_d      = rr_ptr_q;
      drop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = SEND;
               frm_valid_d = 1'b1;
               frm_ch_d    = grant_idx;
               frm_evt_d   = bus.req_evt[grant_idx*EVT_W +: EVT_W];
               cnt_d       = '0;
               rr_ptr_d    = grant_idx;
            end
         end
         SEND: begin
            // An ack on the last allowed cycle still counts as delivered.
            if (bus.frm_ack) begin
               state_d     = IDLE;
               frm_valid_d = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = IDLE;
               frm_valid_d = 1'b0;
               drop        = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      timeout_err_d = timeout_err_q;
      drop_cnt_d    = drop_cnt_q;
      if (err_clr) begin
         timeout_err_d = 1'b0;
         drop_cnt_d    = '0;
      end else if (drop) begin
         timeout_err_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         frm_valid_q   <= 1'b0;
         frm_ch_q      <= '0;
         frm_evt_q     <= '0;
         cnt_q         <= '0;
         rr_ptr_q      <= CH_W'(NUM_CH - 1);
         timeout_err_q <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         frm_valid_q   <= frm_valid_d;
         frm_ch_q      <= frm_ch_d;
         frm_evt_q     <= frm_evt_d;
         cnt_q         <= cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         timeout_err_q <= timeout_err_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign bus.req_ready = accept ? (NUM_CH'(1) << grant_idx) : '0;
   assign bus.frm_valid = frm_valid_q;
   assign bus.frm_ch    = frm_ch_q;
   assign bus.frm_evt   = frm_evt_q;
   assign busy          = (state_q != IDLE);
   assign timeout_err   = timeout_err_q;
   assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_mgmt_smbus_chan_arb.sv
// Bench for mgmt_smbus_chan_arb: grant table, timeout/err_clr/reset sequences,
// then random traffic against an event-level reference model.
module tb_mgmt_smbus_chan_arb;
   localparam int NCH = 4;
   localparam int EW  = 4;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       err_clr = 1'b0;
   logic       busy;
   logic       timeout_err;
   logic [7:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   mgmt_smbus_chan_arb_if #(.NUM_CH(NCH), .EVT_W(EW)) bus ();

   mgmt_smbus_chan_arb #(.NUM_CH(NCH), .EVT_W(EW), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .err_clr     (err_clr),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic [15:0] evt;
      logic [3:0]  exp_ready;
      int          exp_ch;
      logic [3:0]  exp_evt;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.frm_slot = 1'b0; bus.req_valid = '0; bus.req_evt = '0; bus.frm_ack = 1'b0;
      err_clr = 1'b0; enable = 1'b1;
      cyc(); cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   // One accepted event on ch0 left unacked until the end; optional ack/clear on its last SEND cycle.
   task automatic run_timeout(input bit clr_at_end, input bit ack_at_end);
      bus.req_valid = 4'b0001; bus.req_evt = 16'h0005; bus.frm_slot = 1'b1;
      settle(); cyc();
      bus.frm_slot = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         if (i == TMO - 1) begin
            err_clr = clr_at_end;
            bus.frm_ack = ack_at_end;
            settle();
            chk("to_valid_last", bus.frm_valid, 1'b1);
         end
         cyc();
      end
      err_clr = 1'b0; bus.frm_ack = 1'b0;
   endtask

   function automatic int pick(input int last, input logic [3:0] rv);
      for (int k = 1; k <= NCH; k++)
         if (rv[(last + k) % NCH]) return (last + k) % NCH;
      return -1;
   endfunction

   initial begin
      int m_busy, m_ch, m_last, m_age, m_drops, m_err, g, dropped;
      logic [3:0] m_evt, exp_ready;

      vt[0]  = '{4'b1111, 16'h4321, 4'b0001, 0, 4'h1};
      vt[1]  = '{4'b1111, 16'h8765, 4'b0010, 1, 4'h6};
      vt[2]  = '{4'b1111, 16'h4321, 4'b0100, 2, 4'h3};
      vt[3]  = '{4'b1111, 16'h4321, 4'b1000, 3, 4'h4};
      vt[4]  = '{4'b1111, 16'hFEDC, 4'b0001, 0, 4'hC};
      vt[5]  = '{4'b1111, 16'hFEDC, 4'b0010, 1, 4'hD};
      vt[6]  = '{4'b1111, 16'hFEDC, 4'b0100, 2, 4'hE};
      vt[7]  = '{4'b1111, 16'hFEDC, 4'b1000, 3, 4'hF};
      vt[8]  = '{4'b0010, 16'hA5A5, 4'b0010, 1, 4'hA};
      vt[9]  = '{4'b1010, 16'h1234, 4'b1000, 3, 4'h1};
      vt[10] = '{4'b1010, 16'h1234, 4'b0010, 1, 4'h3};
      vt[11] = '{4'b0101, 16'h9876, 4'b0100, 2, 4'h8};
      vt[12] = '{4'b0101, 16'h9876, 4'b0001, 0, 4'h6};
      vt[13] = '{4'b1000, 16'h7000, 4'b1000, 3, 4'h7};

      do_reset();
      settle();
      chk("rst_valid", bus.frm_valid, 1'b0);
      chk("rst_ch", bus.frm_ch, 2'd0);
      chk("rst_evt", bus.frm_evt, 4'h0);
      chk("rst_ready", bus.req_ready, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", timeout_err, 1'b0);
      chk("rst_drop", drop_cnt, 8'd0);
      cyc();

      // Grant table: slot, then ack on the first SEND cycle, next slot right after the return.
      foreach (vt[i]) begin
         bus.req_valid = vt[i].rv; bus.req_evt = vt[i].evt; bus.frm_slot = 1'b1;
         settle();
         chk("tbl_idle_valid", bus.frm_valid, 1'b0);
         chk("tbl_ready", bus.req_ready, vt[i].exp_ready);
         cyc();
         bus.frm_slot = 1'b0; bus.frm_ack = 1'b1;
         settle();
         chk("tbl_valid", bus.frm_valid, 1'b1);
         chk("tbl_ch", bus.frm_ch, vt[i].exp_ch);
         chk("tbl_evt", bus.frm_evt, vt[i].exp_evt);
         cyc();
         bus.frm_ack = 1'b0;
      end

      // Single event held for two SEND cycles before the ack.
      bus.req_valid = 4'b0001; bus.req_evt = 16'h0003; bus.frm_slot = 1'b1;
      settle(); chk("t1_ready", bus.req_ready, 4'b0001); cyc();
      bus.frm_slot = 1'b0;
      settle();
      chk("t1_valid", bus.frm_valid, 1'b1);
      chk("t1_ch", bus.frm_ch, 2'd0);
      chk("t1_evt", bus.frm_evt, 4'h3);
      cyc();
      settle(); chk("t1_hold", bus.frm_valid, 1'b1); cyc();
      bus.frm_ack = 1'b1; settle(); cyc();
      bus.frm_ack = 1'b0;
      settle();
      chk("t1_done_valid", bus.frm_valid, 1'b0);
      chk("t1_done_busy", busy, 1'b0);
      cyc();

      // Timeouts, saturation, clear, ack-wins and clear-wins.
      run_timeout(1'b0, 1'b0);
      settle();
      chk("to_valid", bus.frm_valid, 1'b0);
      chk("to_err", timeout_err, 1'b1);
      chk("to_drop1", drop_cnt, 8'd1);
      chk("to_busy", busy, 1'b0);
      cyc();
      repeat (299) run_timeout(1'b0, 1'b0);
      settle();
      chk("to_sat", drop_cnt, 8'd255);
      chk("to_sat_err", timeout_err, 1'b1);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      settle();
      chk("clr_err", timeout_err, 1'b0);
      chk("clr_drop", drop_cnt, 8'd0);
      cyc();
      run_timeout(1'b0, 1'b1);
      settle();
      chk("ackwin_valid", bus.frm_valid, 1'b0);
      chk("ackwin_err", timeout_err, 1'b0);
      chk("ackwin_drop", drop_cnt, 8'd0);
      cyc();
      run_timeout(1'b0, 1'b0);
      run_timeout(1'b1, 1'b0);
      settle();
      chk("clrwin_err", timeout_err, 1'b0);
      chk("clrwin_drop", drop_cnt, 8'd0);
      cyc();

      // Slot during SEND is missed, not queued.
      bus.req_valid = 4'b1111; bus.req_evt = 16'h2222; bus.frm_slot = 1'b1;
      settle(); cyc();
      settle();
      chk("slot_send_ready", bus.req_ready, 4'b0000);
      cyc();
      bus.frm_slot = 1'b0; bus.frm_ack = 1'b1; settle(); cyc();
      bus.frm_ack = 1'b0;
      settle(); chk("slot_noqueue", bus.frm_valid, 1'b0); cyc();
      settle(); chk("slot_noqueue2", bus.frm_valid, 1'b0); cyc();

      // Disabled: no grants even with slots and pending requests.
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.frm_slot = 1'b1; settle();
         chk("dis_ready", bus.req_ready, 4'b0000);
         cyc();
         bus.frm_slot = 1'b0; settle();
         chk("dis_valid", bus.frm_valid, 1'b0);
         cyc();
      end

      // enable falling in SEND does not abort.
      enable = 1'b1; bus.frm_slot = 1'b1; settle(); cyc();
      bus.frm_slot = 1'b0; enable = 1'b0; settle(); cyc();
      settle(); chk("dis_send_valid", bus.frm_valid, 1'b1); cyc();
      bus.frm_ack = 1'b1; settle(); cyc(); bus.frm_ack = 1'b0;
      settle(); chk("dis_send_done", bus.frm_valid, 1'b0); cyc();

      // Reset mid-SEND with the sticky error set: outputs clear without an edge.
      enable = 1'b1;
      run_timeout(1'b0, 1'b0);
      bus.req_valid = 4'b1111; bus.req_evt = 16'hABCD; bus.frm_slot = 1'b1;
      settle(); cyc();
      bus.frm_slot = 1'b0; settle();
      chk("mid_valid_pre", bus.frm_valid, 1'b1);
      chk("mid_err_pre", timeout_err, 1'b1);
      cyc();
      bus.frm_slot = 1'b1; reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.frm_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ch", bus.frm_ch, 2'd0);
      chk("mid_rst_evt", bus.frm_evt, 4'h0);
      chk("mid_rst_ready", bus.req_ready, 4'b0000);
      chk("mid_rst_err", timeout_err, 1'b0);
      chk("mid_rst_drop", drop_cnt, 8'd0);
      bus.frm_slot = 1'b0;
      cyc(); cyc();
      reset_n = 1'b1; bus.frm_slot = 1'b1;
      settle(); chk("mid_rst_rr", bus.req_ready, 4'b0001); cyc();
      bus.frm_slot = 1'b0; bus.frm_ack = 1'b1;
      settle(); chk("mid_rst_evt2", bus.frm_evt, 4'hD); cyc();
      bus.frm_ack = 1'b0;

      // Random traffic against an event-level model.
      do_reset();
      m_busy = 0; m_ch = 0; m_evt = '0; m_last = NCH - 1; m_age = 0; m_drops = 0; m_err = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.frm_slot  = ($urandom_range(0, 2) == 0);
         bus.req_valid = 4'($urandom);
         bus.req_evt   = 16'($urandom);
         bus.frm_ack   = ($urandom_range(0, 3) == 0);
         enable        = ($urandom_range(0, 7) != 0);
         err_clr       = ($urandom_range(0, 39) == 0);
         settle();
         g = (!m_busy && enable && bus.frm_slot) ? pick(m_last, bus.req_valid) : -1;
         exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
         chk("rnd_ready", bus.req_ready, exp_ready);
         chk("rnd_valid", bus.frm_valid, m_busy);
         chk("rnd_busy", busy, m_busy);
         chk("rnd_err", timeout_err, m_err);
         chk("rnd_drop", drop_cnt, m_drops);
         if (m_busy != 0) begin
            chk("rnd_ch", bus.frm_ch, m_ch);
            chk("rnd_evt", bus.frm_evt, m_evt);
         end
         dropped = 0;
         if (g >= 0) begin
            m_busy = 1; m_ch = g; m_evt = bus.req_evt[g*4 +: 4]; m_age = 0; m_last = g;
         end else if (m_busy != 0) begin
            if (bus.frm_ack) m_busy = 0;
            else begin
               m_age++;
               if (m_age == TMO) begin m_busy = 0; dropped = 1; end
            end
         end
         if (err_clr) begin m_err = 0; m_drops = 0; end
         else if (dropped != 0) begin m_err = 1; if (m_drops < 255) m_drops++; end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mgmt_smbus_chan_arb.md
Name: mgmt_smbus_chan_arb

Overview:
- Arbitrates between NUM_CH SMBus relay channels for the single SMBus-event field of the LTPI management frame.
- Each channel's relay engine posts an event, for example START, data bit, ACK or STOP.
- On every frame slot the block grants one pending channel round-robin and presents the event to the frame TX.
- It holds the event until the frame TX acknowledges it, or drops the event after a timeout.

Parameters:
- NUM_CH, 4, number of requesting SMBus relay channels (2..8).
- EVT_W, 4, width of an SMBus relay event code.
- TIMEOUT, 256, number of SEND cycles without frm_ack before the event is dropped (≥2).
- CH_W, $clog2(NUM_CH), derived width of the channel index; not to be overridden.

Ports:
- clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new grants are issued.
- frm_slot  in  1  one-cycle pulse: a management frame slot is available.
- req_valid  in  NUM_CH  per-channel event pending.
- req_evt  in  NUM_CH*EVT_W  per-channel event code; channel i occupies bits [i*EVT_W +: EVT_W].
- req_ready  out  NUM_CH  one-hot accept strobe.
- frm_valid  out  1  event presented to the frame TX.
- frm_ch  out  CH_W  granted channel index.
- frm_evt  out  EVT_W  granted event code.
- frm_ack  in  1  frame TX has consumed the event.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky flag: at least one event has been dropped.
- err_clr  in  1  clears timeout_err and drop_cnt.
- drop_cnt  out  8  count of dropped events; saturates at 255.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; frm_valid=0; frm_ch=0; frm_evt=0.
  - req_ready=0; busy=0; timeout_err=0; drop_cnt=0; timeout counter=0.
  - rr_ptr=NUM_CH-1, so that ch0 has first priority.
- Reset mid-SEND discards the in-flight event. The requester has already seen its handshake, so the event is lost; this is accepted.
- FSM state IDLE:
  - Accept condition: enable=1, frm_slot=1 and |req_valid.
  - Grant index g = first i with req_valid[i]=1, searching (rr_ptr+1) mod NUM_CH upward with wrap.
  - req_ready is combinational: req_ready[g]=1 in the accept cycle only, and 0 in all other cycles and states.
  - On the accept edge: frm_ch<=g, frm_evt<=req_evt[g], frm_valid<=1, counter<=0, rr_ptr<=g, state<=SEND.
  - Latency: frm_valid rises exactly 1 cycle after the accepted frm_slot.
  - frm_slot with no req_valid, or with enable=0: no action.
- FSM state SEND:
  - frm_valid=1; frm_ch and frm_evt are held stable.
  - frm_ack=1: frm_valid<=0 and state<=IDLE. frm_ack may arrive in the first SEND cycle.
  - frm_ack=0: counter increments.
  - Counter reaching TIMEOUT-1 with frm_ack=0 on that cycle: frm_valid<=0, timeout_err<=1, drop_cnt increments (saturating), state<=IDLE.
  - frm_ack and the timeout condition in the same cycle: ack wins, nothing is dropped.
  - frm_slot pulses during SEND are ignored (the slot is missed); they are not queued.
  - enable falling during SEND does not abort; the in-flight event completes or times out.
- After a return to IDLE, the next accept can occur no earlier than the cycle after the return. Back-to-back frames are therefore ≥2 cycles apart.
- Fairness: with all channels continuously valid, grants cycle 0,1,...,NUM_CH-1,0... A channel that drops valid is skipped with no lost turn for the others.
- err_clr:
  - synchronous; clears timeout_err and drop_cnt on the next edge.
  - has priority over a simultaneous drop; the drop is not counted.
- frm_ack in IDLE is ignored.
- busy = (state != IDLE).

Test Plan:
1. Reset, then req_valid=4'b0001 with evt ch0=4'h3 and one frm_slot pulse.
   - req_ready=0001 in the same cycle.
   - Next cycle: frm_valid=1, frm_ch=0, frm_evt=3.
   - frm_ack 2 cycles later → frm_valid=0, busy=0.
2. All 4 channels valid, 8 slots, each acked after 1 cycle → grant order 0,1,2,3,0,1,2,3. Each req_ready pulse aligns with its slot.
3. req_valid=1010 with rr_ptr=1 → grant ch3. Next slot → grant ch1 (wrap check).
4. TIMEOUT=8, no ack.
   - frm_valid drops after 8 SEND cycles; timeout_err=1; drop_cnt=1.
   - Repeat 300 times → drop_cnt=255 (saturation).
   - err_clr → both return to 0.
   - frm_ack on the final timeout cycle → no drop.
5. Second frm_slot during SEND → ignored, no second req_ready.
   - enable=0 with valid pending and slot pulses → no grant.
   - reset_n asserted mid-SEND → all outputs at reset values immediately, with no clock edge needed.
